// File: rtl/rr_mux_stage_if.sv
// Handshake bundle between N producer channels, the mux stage and one consumer.
interface rr_mux_stage_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  // Producer/consumer side: drives input streams and output ready.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );

  // Mux stage side.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );
endinterface

// File: rtl/rr_mux_stage.sv
// N-channel registered multiplexer with valid/ready on every port.
// One requesting channel is granted whenever the output register can load,
// using round-robin (RR=1) or lowest-index-first (RR=0) ordering.
module rr_mux_stage #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RR = 1
) (
  input  logic          clk,
  input  logic          rst,
  rr_mux_stage_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic          load_en;
  logic          grant_vld;
  logic [SW-1:0] grant_idx;
  logic [SW-1:0] scan_base;
  logic [SW-1:0] cand;
  logic          xfer;
  logic [N-1:0]  grant_oh;

  // The register may load when empty or when its word leaves this cycle.
  assign load_en   = !out_valid_q || bus.out_ready;
  // Fixed priority is round-robin with the scan always starting at 0.
  assign scan_base = (RR != 0) ? ptr_q : '0;
  // Reset blocks every transfer so nothing is accepted on the reset edge.
  assign xfer      = !rst && load_en && grant_vld;

  // Scan channels from scan_base upward, wrapping modulo N; first valid wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(scan_base) + k >= N) begin
        cand = SW'(int'(scan_base) + k - N);
      end else begin
        cand = SW'(int'(scan_base) + k);
      end
      if (!grant_vld && bus.in_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // One-hot ready toward the granted producer, only when the transfer happens.
  always_comb begin
    grant_oh = '0;
    if (xfer) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign bus.in_ready = grant_oh;

  // Next state: load on transfer, drop valid on consume without reload, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[int'(grant_idx)*W +: W];
      out_sel_d   = grant_idx;
      if (RR != 0) begin
        // Pointer moves just past the winner so it has lowest priority next.
        ptr_d = (int'(grant_idx) == N - 1) ? '0 : SW'(int'(grant_idx) + 1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      // Data and select keep their last values after the word is consumed.
      out_valid_d = 1'b0;
    end
  end

  // Output register and arbitration pointer, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux_stage.sv
// Directed bench for rr_mux_stage: one round-robin and one fixed-priority instance.
module tb_rr_mux_stage;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  rr_mux_stage_if #(.N(4), .W(8)) ifa ();
  rr_mux_stage_if #(.N(4), .W(8)) ifb ();

  rr_mux_stage #(.N(4), .W(8), .RR(1)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  rr_mux_stage #(.N(4), .W(8), .RR(0)) dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.in_valid = 4'hF;
    ifa.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ifa.out_ready = 1'b1;
    ifb.in_valid = 4'h0;
    ifb.in_data = '0;
    ifb.out_ready = 1'b1;
    cyc();
    n_cmp++;
    if (ifa.out_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset out_valid got %b want 0", ifa.out_valid);
    end
    n_cmp++;
    if (ifa.out_data !== 8'h00) begin
      n_mis++; $display("FAIL reset out_data got %h want 00", ifa.out_data);
    end
    n_cmp++;
    if (ifa.out_sel !== 2'd0) begin
      n_mis++; $display("FAIL reset out_sel got %0d want 0", ifa.out_sel);
    end
    n_cmp++;
    if (ifa.in_ready !== 4'b0000) begin
      n_mis++; $display("FAIL reset in_ready got %b want 0000", ifa.in_ready);
    end
    n_cmp++;
    if (ifb.out_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset fp out_valid got %b want 0", ifb.out_valid);
    end
    cyc();
    rst = 1'b0;
    ifa.in_valid = 4'h0;
    cyc();
    n_cmp++;
    if (ifa.out_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset idle out_valid got %b want 0", ifa.out_valid);
    end
  endtask

  task automatic test_rr_sequence();
    logic [1:0] es;
    ifa.in_valid = 4'hF;
    ifa.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      es = 2'(k % 4);
      #1;
      n_cmp++;
      if (ifa.in_ready !== (4'b0001 << es)) begin
        n_mis++; $display("FAIL rr_seq in_ready k=%0d got %b want %b", k, ifa.in_ready, 4'b0001 << es);
      end
      cyc();
      n_cmp++;
      if (ifa.out_valid !== 1'b1 || ifa.out_sel !== es || ifa.out_data !== (8'hA0 + 8'(es))) begin
        n_mis++;
        $display("FAIL rr_seq out k=%0d got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                 k, ifa.out_valid, ifa.out_sel, ifa.out_data, es, 8'hA0 + 8'(es));
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_sel [3];
    exp_sel[0] = 2'd3; exp_sel[1] = 2'd0; exp_sel[2] = 2'd3;
    // Pointer is 0 here; granting channel 1 moves it to 2.
    ifa.in_valid = 4'b0010;
    ifa.in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    cyc();
    n_cmp++;
    if (ifa.out_sel !== 2'd1 || ifa.out_data !== 8'hD1) begin
      n_mis++; $display("FAIL wrap setup got sel=%0d data=%h want sel=1 data=d1", ifa.out_sel, ifa.out_data);
    end
    ifa.in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (ifa.in_ready !== (4'b0001 << exp_sel[k])) begin
        n_mis++; $display("FAIL wrap in_ready k=%0d got %b want %b", k, ifa.in_ready, 4'b0001 << exp_sel[k]);
      end
      cyc();
      n_cmp++;
      if (ifa.out_sel !== exp_sel[k] || ifa.out_valid !== 1'b1) begin
        n_mis++; $display("FAIL wrap sel k=%0d got %0d v=%b want %0d v=1", k, ifa.out_sel, ifa.out_valid, exp_sel[k]);
      end
    end
    ifa.in_valid = 4'h0;
    cyc();
  endtask

  task automatic test_backpressure();
    // Pointer is 0; load 5A from channel 2, pointer becomes 3.
    ifa.in_valid = 4'b0100;
    ifa.in_data = {8'h00, 8'h5A, 8'h77, 8'h00};
    ifa.out_ready = 1'b1;
    cyc();
    ifa.in_valid = 4'b0010;
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (ifa.in_ready !== 4'b0000) begin
        n_mis++; $display("FAIL stall in_ready k=%0d got %b want 0000", k, ifa.in_ready);
      end
      cyc();
      n_cmp++;
      if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'h5A || ifa.out_sel !== 2'd2) begin
        n_mis++;
        $display("FAIL stall hold k=%0d got v=%b data=%h sel=%0d want v=1 data=5a sel=2",
                 k, ifa.out_valid, ifa.out_data, ifa.out_sel);
      end
    end
    ifa.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (ifa.in_ready !== 4'b0010) begin
      n_mis++; $display("FAIL release in_ready got %b want 0010", ifa.in_ready);
    end
    cyc();
    n_cmp++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'h77 || ifa.out_sel !== 2'd1) begin
      n_mis++;
      $display("FAIL release load got v=%b data=%h sel=%0d want v=1 data=77 sel=1",
               ifa.out_valid, ifa.out_data, ifa.out_sel);
    end
    ifa.in_valid = 4'h0;
    cyc();
    n_cmp++;
    if (ifa.out_valid !== 1'b0) begin
      n_mis++; $display("FAIL release drain out_valid got %b want 0", ifa.out_valid);
    end
  endtask

  task automatic test_fixed_priority();
    ifb.in_valid = 4'b0110;
    ifb.in_data = {8'h33, 8'h22, 8'h11, 8'h00};
    ifb.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (ifb.in_ready !== 4'b0010) begin
        n_mis++; $display("FAIL fixed in_ready k=%0d got %b want 0010", k, ifb.in_ready);
      end
      cyc();
      n_cmp++;
      if (ifb.out_sel !== 2'd1 || ifb.out_data !== 8'h11 || ifb.out_valid !== 1'b1) begin
        n_mis++;
        $display("FAIL fixed out k=%0d got sel=%0d data=%h v=%b want sel=1 data=11 v=1",
                 k, ifb.out_sel, ifb.out_data, ifb.out_valid);
      end
    end
    ifb.in_valid = 4'b0100;
    #1;
    n_cmp++;
    if (ifb.in_ready !== 4'b0100) begin
      n_mis++; $display("FAIL fixed drop in_ready got %b want 0100", ifb.in_ready);
    end
    cyc();
    n_cmp++;
    if (ifb.out_sel !== 2'd2 || ifb.out_data !== 8'h22) begin
      n_mis++; $display("FAIL fixed drop got sel=%0d data=%h want sel=2 data=22", ifb.out_sel, ifb.out_data);
    end
    ifb.in_valid = 4'h0;
    cyc();
  endtask

  task automatic test_drain();
    // Pointer is 2 after the backpressure scenario; only channel 0 requests.
    ifa.in_valid = 4'b0001;
    ifa.in_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    ifa.out_ready = 1'b1;
    cyc();
    n_cmp++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 8'h3C || ifa.out_sel !== 2'd0) begin
      n_mis++;
      $display("FAIL drain load got v=%b data=%h sel=%0d want v=1 data=3c sel=0",
               ifa.out_valid, ifa.out_data, ifa.out_sel);
    end
    ifa.in_valid = 4'h0;
    ifa.in_data = '0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      n_cmp++;
      if (ifa.out_valid !== 1'b0 || ifa.out_data !== 8'h3C || ifa.out_sel !== 2'd0) begin
        n_mis++;
        $display("FAIL drain empty k=%0d got v=%b data=%h sel=%0d want v=0 data=3c sel=0",
                 k, ifa.out_valid, ifa.out_data, ifa.out_sel);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Pointer is 1 after granting channel 0; all valid grants channel 1.
    ifa.in_valid = 4'hF;
    ifa.in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    ifa.out_ready = 1'b1;
    cyc();
    n_cmp++;
    if (ifa.out_valid !== 1'b1 || ifa.out_sel !== 2'd1 || ifa.out_data !== 8'hA1) begin
      n_mis++;
      $display("FAIL rstmid load got v=%b sel=%0d data=%h want v=1 sel=1 data=a1",
               ifa.out_valid, ifa.out_sel, ifa.out_data);
    end
    ifa.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ifa.in_ready !== 4'b0000) begin
      n_mis++; $display("FAIL rstmid in_ready got %b want 0000", ifa.in_ready);
    end
    cyc();
    n_cmp++;
    if (ifa.out_valid !== 1'b0 || ifa.out_data !== 8'h00 || ifa.out_sel !== 2'd0) begin
      n_mis++;
      $display("FAIL rstmid cleared got v=%b data=%h sel=%0d want v=0 data=00 sel=0",
               ifa.out_valid, ifa.out_data, ifa.out_sel);
    end
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (ifa.in_ready !== 4'b0001) begin
      n_mis++; $display("FAIL rstmid restart in_ready got %b want 0001", ifa.in_ready);
    end
    cyc();
    n_cmp++;
    if (ifa.out_valid !== 1'b1 || ifa.out_sel !== 2'd0 || ifa.out_data !== 8'hA0) begin
      n_mis++;
      $display("FAIL rstmid restart got v=%b sel=%0d data=%h want v=1 sel=0 data=a0",
               ifa.out_valid, ifa.out_sel, ifa.out_data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    test_reset();
    test_rr_sequence();
    test_wrap();
    test_backpressure();
    test_fixed_priority();
    test_drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
